// File: rtl/md_unit_ctrl_pkg.sv
// ============================================================================
// Module  : md_unit_ctrl_pkg
// Brief   : Shared multiply/divide definitions: MD op codes, sequencer state
//           encodings and op classification helpers. MainControl and the
//           hazard unit reuse the op codes.
// Config  : MD_MADD_EN - when defined, MADD/MADDU/MSUB are start ops.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package md_unit_ctrl_pkg;

    // MD op codes carried with the instruction down the pipeline
    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8,
        MD_MADD  = 4'd9,
        MD_MADDU = 4'd10,
        MD_MSUB  = 4'd11
    } md_op_e;

    // Sequencer state encodings
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    localparam int unsigned C_CNT_W = 4;

    // Op codes that launch a multi-cycle operation
    function automatic logic md_is_start_op(input logic [3:0] op);
        logic r;
        r = 1'b0;
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: r = 1'b1;
`ifdef MD_MADD_EN
            MD_MADD, MD_MADDU, MD_MSUB:         r = 1'b1;
`endif
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

    // Divide ops take the divide latency; everything else the multiply latency
    function automatic logic md_is_div_op(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/md_unit_ctrl_compute.sv
// ============================================================================
// Module  : md_compute
// Brief   : Purely combinational 64-bit {HI,LO} result for the latched MD op
//           and operands, plus the divide-by-zero hold flag.
// Config  : MD_MADD_EN - adds MADD/MADDU/MSUB accumulate results.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module md_compute
    import md_unit_ctrl_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    output logic [63:0] result_o,
    output logic        hold_o
);

    logic        w_a_neg;
    logic        w_b_neg;
    logic        w_b_zero;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_b_safe;
    logic [31:0] w_bmag_safe;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_sq_mag;
    logic [31:0] w_sr_mag;
    logic [31:0] w_sq;
    logic [31:0] w_sr;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [63:0] w_hilo;

    // Signed divide is done on magnitudes so INT_MIN / -1 falls out naturally
    // as 0x80000000 with a zero remainder. A zero divisor is replaced by 1
    // so the dividers never see it; the hold flag discards the result.
    always_comb begin
        w_a_neg     = a_i[31];
        w_b_neg     = b_i[31];
        w_b_zero    = (b_i == 32'd0);
        w_a_mag     = w_a_neg ? (32'd0 - a_i) : a_i;
        w_b_mag     = w_b_neg ? (32'd0 - b_i) : b_i;
        w_b_safe    = w_b_zero ? 32'd1 : b_i;
        w_bmag_safe = w_b_zero ? 32'd1 : w_b_mag;

        w_uq        = a_i / w_b_safe;
        w_ur        = a_i % w_b_safe;
        w_sq_mag    = w_a_mag / w_bmag_safe;
        w_sr_mag    = w_a_mag % w_bmag_safe;
        w_sq        = (w_a_neg ^ w_b_neg) ? (32'd0 - w_sq_mag) : w_sq_mag;
        w_sr        = w_a_neg ? (32'd0 - w_sr_mag) : w_sr_mag;

        w_prod_s    = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
        w_prod_u    = {32'd0, a_i} * {32'd0, b_i};
        w_hilo      = {hi_i, lo_i};
    end

    // Select the {HI,LO} image for the op; unknown ops keep the current value
    always_comb begin
        result_o = w_hilo;
        case (op_i)
            MD_MULT:  result_o = w_prod_s;
            MD_MULTU: result_o = w_prod_u;
            MD_DIV:   result_o = {w_sr, w_sq};
            MD_DIVU:  result_o = {w_ur, w_uq};
`ifdef MD_MADD_EN
            MD_MADD:  result_o = w_hilo + w_prod_s;
            MD_MADDU: result_o = w_hilo + w_prod_u;
            MD_MSUB:  result_o = w_hilo - w_prod_s;
`endif
            default:  result_o = w_hilo;
        endcase
        hold_o = md_is_div_op(op_i) && w_b_zero;
    end

endmodule

`default_nettype wire

// File: rtl/md_unit_ctrl.sv
// ============================================================================
// Module  : md_unit_ctrl
// Brief   : Multiply/divide sequencer. Owns HI/LO, accepts MD ops from the E
//           stage, models latency with a busy counter and raises the MD stall
//           request for the hazard unit. mfhi/mflo are read combinationally.
// Config  : MD_MADD_EN - enables MADD/MADDU/MSUB (multiply latency).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module md_unit_ctrl
    import md_unit_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_MDOp,
    input  logic        E_Start,
    input  logic [31:0] E_RSData,
    input  logic [31:0] E_RTData,
    input  logic        D_IsMD,
    output logic [31:0] E_MDRead,
    output logic        MD_Busy,
    output logic        MD_Stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [C_CNT_W-1:0] C_MULT_CNT = C_CNT_W'(MULT_CYCLES);
    localparam logic [C_CNT_W-1:0] C_DIV_CNT  = C_CNT_W'(DIV_CYCLES);

    md_state_e            state_q, state_d;
    logic [C_CNT_W-1:0]   count_q, count_d;
    logic [3:0]           op_q,    op_d;
    logic [31:0]          a_q,     a_d;
    logic [31:0]          b_q,     b_d;
    logic [31:0]          hi_q,    hi_d;
    logic [31:0]          lo_q,    lo_d;

    logic [63:0]          w_result;
    logic                 w_hold;

    // Result datapath works only on latched operands; HI/LO feed accumulates
    md_compute u_compute (
        .op_i     (op_q),
        .a_i      (a_q),
        .b_i      (b_q),
        .hi_i     (hi_q),
        .lo_i     (lo_q),
        .result_o (w_result),
        .hold_o   (w_hold)
    );

    // State, counter, latched operation and HI/LO registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            op_q    <= MD_NONE;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Next-state: launch in IDLE, count down in BUSY, write back on the last
    // busy cycle. Starts and mt* while BUSY are ignored.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (E_Start && md_is_start_op(E_MDOp)) begin
                    op_d    = E_MDOp;
                    a_d     = E_RSData;
                    b_d     = E_RTData;
                    count_d = md_is_div_op(E_MDOp) ? C_DIV_CNT : C_MULT_CNT;
                    state_d = ST_BUSY;
                end else if (E_MDOp == MD_MTHI) begin
                    hi_d = E_RSData;
                end else if (E_MDOp == MD_MTLO) begin
                    lo_d = E_RSData;
                end
            end
            ST_BUSY: begin
                count_d = count_q - 1'b1;
                if (count_q == C_CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    if (!w_hold) begin
                        hi_d = w_result[63:32];
                        lo_d = w_result[31:0];
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase
    end

    // mfhi/mflo read port for the E-stage result mux
    always_comb begin
        E_MDRead = 32'd0;
        if (E_MDOp == MD_MFHI) begin
            E_MDRead = hi_q;
        end else if (E_MDOp == MD_MFLO) begin
            E_MDRead = lo_q;
        end
    end

    assign MD_Busy  = (state_q == ST_BUSY);
    assign MD_Stall = D_IsMD & (E_Start | MD_Busy);
    assign HI       = hi_q;
    assign LO       = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_md_unit_ctrl.sv
// ============================================================================
// Module  : tb_md_unit_ctrl
// Brief   : Self-checking bench for md_unit_ctrl (default build, MD_MADD_EN
//           undefined). Expected HI/LO are queued at issue and compared at
//           completion.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_md_unit_ctrl;
    import md_unit_ctrl_pkg::*;

    localparam int C_MULT_N = 5;
    localparam int C_DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic [3:0]  E_MDOp;
    logic        E_Start;
    logic [31:0] E_RSData;
    logic [31:0] E_RTData;
    logic        D_IsMD;
    logic [31:0] E_MDRead;
    logic        MD_Busy;
    logic        MD_Stall;
    logic [31:0] HI;
    logic [31:0] LO;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    int          n_checks;
    int          n_fail;

    md_unit_ctrl #(
        .MULT_CYCLES (C_MULT_N),
        .DIV_CYCLES  (C_DIV_N)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .E_MDOp   (E_MDOp),
        .E_Start  (E_Start),
        .E_RSData (E_RSData),
        .E_RTData (E_RTData),
        .D_IsMD   (D_IsMD),
        .E_MDRead (E_MDRead),
        .MD_Busy  (MD_Busy),
        .MD_Stall (MD_Stall),
        .HI       (HI),
        .LO       (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model built on 64-bit longint arithmetic
    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] hi,
                                          input logic [31:0] lo);
        longint sa, sbv, q, r;
        logic [63:0] res;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        res = {hi, lo};
        case (op)
            MD_MULT:  res = 64'(sa * sbv);
            MD_MULTU: res = {32'h0, a} * {32'h0, b};
            MD_DIV: begin
                if (b != 32'd0) begin
                    q   = sa / sbv;
                    r   = sa % sbv;
                    res = {r[31:0], q[31:0]};
                end
            end
            MD_DIVU: begin
                if (b != 32'd0) res = {a % b, a / b};
            end
            default: res = {hi, lo};
        endcase
        return res;
    endfunction

    task automatic sb_compare(input string tag);
        exp_t e;
        n_checks++;
        assert (sb.size() > 0) else begin
            n_fail++;
            $error("FAIL %s_sb: observed empty scoreboard expected 1 entry", tag);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_hi"}, HI, e.hi);
            chk({tag, "_lo"}, LO, e.lo);
            m_hi = e.hi;
            m_lo = e.lo;
        end
    endtask

    // Issue one MD op, check busy/stall every cycle, then check write-back
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic ismd);
        int   n;
        logic [63:0] r;
        exp_t e;
        n    = md_is_div_op(op) ? C_DIV_N : C_MULT_N;
        r    = model(op, a, b, m_hi, m_lo);
        e.hi = r[63:32];
        e.lo = r[31:0];
        sb.push_back(e);
        @(negedge clk);
        E_MDOp = op; E_Start = 1'b1; E_RSData = a; E_RTData = b; D_IsMD = ismd;
        #1;
        chk({tag, "_stall_t"}, 32'(MD_Stall), 32'(ismd));
        chk({tag, "_busy_t"}, 32'(MD_Busy), 32'd0);
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            E_MDOp = MD_NONE; E_Start = 1'b0;
            E_RSData = $urandom; E_RTData = $urandom;
            #1;
            chk($sformatf("%s_busy_%0d", tag, i), 32'(MD_Busy), 32'd1);
            chk($sformatf("%s_stall_%0d", tag, i), 32'(MD_Stall), 32'(ismd));
        end
        @(negedge clk);
        #1;
        chk({tag, "_busy_end"}, 32'(MD_Busy), 32'd0);
        chk({tag, "_stall_end"}, 32'(MD_Stall), 32'd0);
        sb_compare(tag);
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        m_hi = '0; m_lo = '0;
        reset = 1'b1; E_MDOp = MD_MFHI; E_Start = 1'b0;
        E_RSData = 32'hA5A5A5A5; E_RTData = 32'h5A5A5A5A; D_IsMD = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_busy", 32'(MD_Busy), 32'd0);
        chk("rst_stall", 32'(MD_Stall), 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        chk("rst_mfhi", E_MDRead, 32'd0);

        // mult with mflo waiting in D, then read LO/HI back
        run_op("mult", MD_MULT, 32'hFFFFFFFF, 32'h00000002, 1'b1);
        chk("mult_hi_const", HI, 32'hFFFFFFFF);
        chk("mult_lo_const", LO, 32'hFFFFFFFE);
        @(negedge clk);
        E_MDOp = MD_MFLO;
        #1;
        chk("mflo_read", E_MDRead, 32'hFFFFFFFE);
        @(negedge clk);
        E_MDOp = MD_MFHI;
        #1;
        chk("mfhi_read", E_MDRead, 32'hFFFFFFFF);

        // multu without a dependent D-stage op: no stall at all
        run_op("multu", MD_MULTU, 32'hFFFFFFFF, 32'h00000002, 1'b0);
        chk("multu_hi_const", HI, 32'h00000001);

        run_op("div", MD_DIV, 32'hFFFFFFF9, 32'h00000002, 1'b1);
        chk("div_lo_const", LO, 32'hFFFFFFFD);
        run_op("divu", MD_DIVU, 32'd7, 32'd2, 1'b1);
        chk("divu_lo_const", LO, 32'd3);
        run_op("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b1);
        chk("div_ovf_lo_const", LO, 32'h80000000);

        // mthi / mtlo then divide by zero keeps both
        @(negedge clk);
        E_MDOp = MD_MTHI; E_RSData = 32'h12345678; D_IsMD = 1'b0;
        @(negedge clk);
        E_MDOp = MD_MTLO; E_RSData = 32'h00000000;
        #1;
        chk("mthi", HI, 32'h12345678);
        @(negedge clk);
        E_MDOp = MD_NONE;
        #1;
        chk("mtlo", LO, 32'h00000000);
        m_hi = 32'h12345678; m_lo = 32'h0;
        run_op("div0", MD_DIV, 32'd5, 32'd0, 1'b1);
        chk("div0_hi_const", HI, 32'h12345678);

        // reset during busy cycle 4 aborts the divide
        @(negedge clk);
        E_MDOp = MD_DIV; E_Start = 1'b1; E_RSData = 32'd100; E_RTData = 32'd7; D_IsMD = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            E_MDOp = MD_NONE; E_Start = 1'b0;
            if (i == 4) reset = 1'b1;
            #1;
            chk($sformatf("abort_busy_%0d", i), 32'(MD_Busy), 32'd1);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_busy_after", 32'(MD_Busy), 32'd0);
        chk("abort_hi", HI, 32'd0);
        chk("abort_lo", LO, 32'd0);
        repeat (C_DIV_N) @(negedge clk);
        #1;
        chk("abort_no_late_hi", HI, 32'd0);
        chk("abort_no_late_lo", LO, 32'd0);
        m_hi = '0; m_lo = '0;

        // start while busy is ignored; div completes on its own schedule
        begin
            logic [63:0] r;
            exp_t e;
            r = model(MD_DIV, 32'd100, 32'd7, m_hi, m_lo);
            e.hi = r[63:32]; e.lo = r[31:0];
            sb.push_back(e);
            @(negedge clk);
            E_MDOp = MD_DIV; E_Start = 1'b1; E_RSData = 32'd100; E_RTData = 32'd7;
            for (int i = 1; i <= C_DIV_N; i++) begin
                @(negedge clk);
                E_Start = (i == 2); E_MDOp = (i == 2) ? MD_MULT : MD_NONE;
                E_RSData = 32'd3; E_RTData = 32'd4;
                #1;
                chk($sformatf("ign_busy_%0d", i), 32'(MD_Busy), 32'd1);
            end
            @(negedge clk);
            E_Start = 1'b0; E_MDOp = MD_NONE;
            #1;
            chk("ign_busy_end", 32'(MD_Busy), 32'd0);
            sb_compare("ign");
            chk("ign_lo_const", LO, 32'd14);
            chk("ign_hi_const", HI, 32'd2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/md_unit_ctrl.md
Name: md_unit_ctrl

Overview:
Multiply/divide sequencer for the pipelined CPU. It owns the HI/LO registers and accepts MD operations issued from the E stage. It models multi-cycle latency with a busy counter and drives the stall request that the hazard unit combines with the existing Tuse/Tnew stalls. mfhi/mflo results are returned combinationally to the E-stage result mux.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (valid range 1-15).
DIV_CYCLES, 10, busy cycles for div/divu (valid range 1-15).

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
E_MDOp  input  4  operation code of the E-stage instruction; encodings in the shared package
E_Start  input  1  E-stage instruction is mult/multu/div/divu (qualified, not a bubble)
E_RSData  input  32  forwarded rs operand (after E forward mux)
E_RTData  input  32  forwarded rt operand
D_IsMD  input  1  D-stage instruction uses the MD unit (mult*, div*, mf*, mt*)
E_MDRead  output  32  HI for MD_MFHI, LO for MD_MFLO, else 0
MD_Busy  output  1  operation in flight
MD_Stall  output  1  stall request to the hazard unit: D_IsMD & (E_Start | MD_Busy)
HI  output  32  HI register
LO  output  32  LO register

Behaviour:
- Reset (sync, highest priority): state=IDLE, count=0, HI=0, LO=0, MD_Busy=0. Reset mid-operation aborts it; the pending result is discarded.
- FSM states:
  - IDLE: if E_Start & op ∈ {MULT, MULTU, DIV, DIVU}: latch op and operands, load count = MULT_CYCLES or DIV_CYCLES, go to BUSY.
  - BUSY: count decrements each cycle. When count==1, write the result to HI/LO on that edge and go to IDLE.
- Timing: for E_Start in cycle t, MD_Busy=1 for cycles t+1..t+N. New HI/LO is visible from cycle t+N+1. MD_Busy is registered. MD_Stall is combinational.
- Arithmetic:
  - mult: signed 64-bit product; multu: unsigned. HI=prod[63:32], LO=prod[31:0].
  - div: LO=signed quotient, HI=signed remainder; remainder sign follows the dividend (truncating).
  - divu: unsigned quotient/remainder.
- Divide by zero: the operation still runs for the full DIV_CYCLES with MD_Busy asserted; HI/LO stay unchanged.
- Signed 0x80000000 / -1: LO=0x80000000, HI=0.
- MTHI/MTLO: write HI/LO from E_RSData at the clock edge of the E-stage cycle, only in IDLE. The stall guarantees these never coincide with BUSY; if they do, they are ignored.
- MFHI/MFLO: E_MDRead reads the current register value combinationally.
- E_Start while BUSY (protocol violation, prevented by MD_Stall): ignored, no restart.
- Operands are latched at start; later changes on the E_* inputs do not affect the result.

Optional Feature:
MD_MADD_EN:
- Defined: adds MADD, MADDU and MSUB op codes, each with MULT_CYCLES latency. At completion, {HI,LO} is set to {HI,LO} ± product, 64-bit wrap-around, signed product for MADD/MSUB and unsigned for MADDU. {HI,LO} is sampled at completion, not at start.
- Undefined: these codes are treated as MD_NONE (no start, no busy).

Decomposition:
- Shared package/header md_defs: MD_NONE=0, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MFHI, MD_MFLO, MD_MTHI, MD_MTLO, MD_MADD, MD_MADDU, MD_MSUB; state encodings IDLE/BUSY. MainControl and the hazard unit reuse these codes.
- One natural sub-module: md_compute, purely combinational 64-bit result from the latched op and operands, including the divide-by-zero hold flag. The FSM, counter, HI/LO and stall logic stay in md_unit_ctrl.

Test Plan:
- mult 0xFFFFFFFF × 0x00000002 -> MD_Busy cycles t+1..t+5; HI=0xFFFFFFFF, LO=0xFFFFFFFE at t+6. Same operands with multu -> HI=0x00000001, LO=0xFFFFFFFE.
- div -7/2 (0xFFFFFFF9, 0x2) -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/2 -> LO=3, HI=1.
- mthi 0x12345678, then div 5/0 -> MD_Busy high for 10 cycles; HI stays 0x12345678, LO stays 0.
- mult in E with mflo in D -> MD_Stall=1 for cycle t and for t+1..t+5, 0 at t+6. mflo then returns the product; D_IsMD=0 during busy -> MD_Stall=0.
- Start div, assert reset in busy cycle 4 -> next cycle MD_Busy=0, HI=LO=0, no late write-back.
- E_Start mult while BUSY with a div -> ignored; the div result is written at its original completion cycle.
